// File: rtl/filter_peak_detector.sv
// filter_peak_detector
// Qualifies pulses on the shaped filter output with a hysteresis pair of
// thresholds. It tracks the maximum and its timestamp, and measures the pulse
// width. At the end of each pulse it emits one record on a valid/ready
// handshake. A hold-off window after every pulse suppresses re-triggering on
// the pulse tail.
module filter_peak_detector #(
  parameter int DATA_W    = 22,
  parameter int TS_W      = 32,
  parameter int WID_W     = 12,
  parameter int THR_HI    = 200,
  parameter int THR_LO    = 100,
  parameter int HOLDOFF   = 16,
  parameter int MAX_WIDTH = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic        [TS_W-1:0]   peak_time,
  output logic        [WID_W-1:0]  peak_width,
  output logic                     peak_pileup,
  output logic                     peak_valid,
  input  logic                     peak_ready,
  output logic        [15:0]       drop_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic signed [DATA_W-1:0] THR_HI_S = DATA_W'(THR_HI);
  localparam logic signed [DATA_W-1:0] THR_LO_S = DATA_W'(THR_LO);

  // The hold counter must be able to hold HOLDOFF itself; keep at least one
  // bit so HOLDOFF = 0 still gives a legal vector.
  localparam int                HOLD_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
  localparam logic [WID_W-1:0]  WID_SAT   = '1;
  localparam logic              PILE_ON_ARM = (MAX_WIDTH <= 1);

  // Pulse tracking state
  logic [1:0]               state_reg;
  logic [TS_W-1:0]          ts_reg;
  logic signed [DATA_W-1:0] max_reg;
  logic [TS_W-1:0]          tmax_reg;
  logic [WID_W-1:0]         width_reg;
  logic                     pileup_reg;
  logic [HOLD_W-1:0]        hold_reg;

  // One-record output register
  logic signed [DATA_W-1:0] amp_reg;
  logic [TS_W-1:0]          time_reg;
  logic [WID_W-1:0]         owidth_reg;
  logic                     opileup_reg;
  logic                     valid_reg;
  logic [15:0]              drop_reg;

  logic             pulse_end;
  logic             arm;
  logic [WID_W-1:0] width_next;
  logic             width_hits_max;
  logic             xfer;

  // End/arm decisions and the saturating width increment
  always_comb begin
    pulse_end      = (state_reg == ARMED) && (filter_data < THR_LO_S);
    arm            = (state_reg == IDLE) && (filter_data > THR_HI_S);
    width_next     = (width_reg == WID_SAT) ? width_reg : width_reg + WID_W'(1);
    width_hits_max = (int'(width_next) >= MAX_WIDTH);
    xfer           = valid_reg && peak_ready;
  end

  // Timestamp and pulse FSM: arm, track the maximum, end, then hold off
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ts_reg     <= '0;
      max_reg    <= '0;
      tmax_reg   <= '0;
      width_reg  <= '0;
      pileup_reg <= 1'b0;
      hold_reg   <= '0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);
      case (state_reg)
        IDLE: begin
          if (arm) begin
            state_reg  <= ARMED;
            max_reg    <= filter_data;
            tmax_reg   <= ts_reg;
            width_reg  <= WID_W'(1);
            pileup_reg <= PILE_ON_ARM;
          end
        end
        ARMED: begin
          if (pulse_end) begin
            state_reg <= HOLD;
            hold_reg  <= HOLD_LOAD;
          end else begin
            width_reg <= width_next;
            if (width_hits_max) begin
              pileup_reg <= 1'b1;
            end
            // Strict compare: ties keep the earliest timestamp
            if (filter_data > max_reg) begin
              max_reg  <= filter_data;
              tmax_reg <= ts_reg;
            end
          end
        end
        HOLD: begin
          if (hold_reg == '0) begin
            state_reg <= IDLE;
          end else begin
            hold_reg <= hold_reg - HOLD_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output record: load on pulse end when the slot is free or draining this
  // edge, otherwise drop the new record and count it
  always_ff @(posedge clk) begin
    if (reset) begin
      amp_reg     <= '0;
      time_reg    <= '0;
      owidth_reg  <= '0;
      opileup_reg <= 1'b0;
      valid_reg   <= 1'b0;
      drop_reg    <= '0;
    end else if (pulse_end) begin
      if (!valid_reg || peak_ready) begin
        amp_reg     <= max_reg;
        time_reg    <= tmax_reg;
        owidth_reg  <= width_reg;
        opileup_reg <= pileup_reg;
        valid_reg   <= 1'b1;
      end else if (drop_reg != 16'hFFFF) begin
        drop_reg <= drop_reg + 16'd1;
      end
    end else if (xfer) begin
      valid_reg <= 1'b0;
    end
  end

  assign peak_amp    = amp_reg;
  assign peak_time   = time_reg;
  assign peak_width  = owidth_reg;
  assign peak_pileup = opileup_reg;
  assign peak_valid  = valid_reg;
  assign drop_cnt    = drop_reg;

endmodule
